usb_tx_encoder: RTL and testbench
=================================

// Module: usb_tx_encoder
// PURPOSE
//  Transmit side of the USB full-speed link: serialises bytes LSB-first, prepends SYNC, bit-stuffs,
//  NRZI-encodes onto d_plus/d_minus, and appends EOP. Sits between the packet builder (byte
//  valid/ready stream) and the bus drivers; mirror of the receive-side NRZI decode path.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per USB bit time (>=2)
// PORTS
//  clk            in   1  system clock
//  n_rst          in   1  async reset, active-low
//  tx_data        in   8  byte to send, LSB transmitted first
//  tx_data_valid  in   1  byte available; high in IDLE starts a packet
//  tx_data_ready  out  1  1-clk pulse: tx_data accepted this clk (valid & ready)
//  d_plus         out  1  D+ line
//  d_minus        out  1  D- line
//  tx_busy        out  1  high from packet start through end of EOP J bit
//  tx_done        out  1  1-clk pulse after the EOP J bit completes
// BEHAVIOUR
//  Reset, asynchronous, active-low on n_rst; clock clk. Reset values: d_plus=1, d_minus=0 (J/idle),
//   tx_busy=0, tx_done=0, tx_data_ready=0, ones_cnt=0, bit timer=0, state=IDLE.
//  Line: J={1,0}, K={0,1}, SE0={0,0}. NRZI: data 0 -> toggle J/K, data 1 -> hold level.
//  Bit timer: counts 0..CLKS_PER_BIT-1; line changes only on the clk where timer wraps (bit edge).
//  FSM: IDLE -> SYNC -> DATA -> EOP_SE0 -> EOP_J -> IDLE.
//   IDLE: tx_data_valid=1 -> tx_data_ready pulses same clk, byte loaded, timer cleared, -> SYNC.
//   SYNC: 8 bits 8'b1000_0000 (LSB first 0000_0001) -> line KJKJKJKK; ones_cnt=1 on exit.
//   DATA: shifts byte. During last bit-time clk of each byte: if tx_data_valid, ready pulses and next
//    byte loads with no gap; else packet ends -> EOP_SE0 after that bit (plus any pending stuff bit).
//   EOP_SE0: 2 bit times SE0. EOP_J: 1 bit time J; at its end tx_done pulses, tx_busy drops.
//  Bit stuffing: ones_cnt counts consecutive transmitted 1s; 0 resets it. After the 6th 1, next bit
//   time is a stuffed 0 (toggle), ones_cnt=0, data shift stalls one bit. Applies across byte
//   boundaries and after the final data bit (stuff bit precedes EOP). SYNC bits count toward ones_cnt.
//  Byte-accept stall: ready pulse is delayed until the last bit actually sent (not the stuff bit).
//  tx_data_valid ignored outside IDLE and byte-boundary clk. No back-to-back packet: IDLE entry is
//   one clk minimum with J before next SYNC.
//  Reset mid-packet: line returns to J immediately (async), all state cleared, no tx_done.
// CONFIGURATION
//  USB_TX_ABORT_EN defined: adds input tx_abort (1 bit). tx_abort=1 in SYNC/DATA -> at next bit edge
//   transmit 8 data 1s with stuffing suppressed (stuff error), then normal EOP; tx_done still pulses;
//   ignored in IDLE/EOP states.
//  USB_TX_ABORT_EN undefined: no tx_abort port; packets end only by valid low at byte boundary.
// STRUCTURE
//  Package usb_tx_pkg: state enum (IDLE,SYNC,DATA,EOP_SE0,EOP_J), SYNC_BYTE=8'h80, STUFF_LIMIT=6,
//   line-state constants LINE_J/LINE_K/LINE_SE0 (2-bit {d_plus,d_minus}), EOP_SE0_BITS=2.
//  Sub-module usb_tx_bit_timer (param CLKS_PER_BIT): outputs bit_edge strobe, clear input.
// TESTING (CLKS_PER_BIT=8)
//  Reset asserted mid-DATA -> d_plus=1,d_minus=0, tx_busy=0 same cycle; no tx_done after release.
//  Single byte 8'h00 -> ready pulse at start; KJKJKJKK then JKJKJKJK per 8 clk, 16 clk SE0, 8 clk J,
//   tx_done 1 clk, total 19 bit times.
//  Byte 8'hFF -> after SYNC (one 1) five holds then stuff toggle, then three holds; 1 extra bit time.
//  Bytes 8'hFF,8'hFF back-to-back -> second ready pulse exactly at first byte's last bit; stuffs at
//   correct positions across boundary; stuff bit before EOP when run ends at final bit.
//  Bytes 8'hA5,8'h3C with valid dropped after 2nd accept -> exact NRZI line per bit, EOP follows.
//  USB_TX_ABORT_EN: tx_abort during byte 1 -> 8 held levels (no stuff), SE0 x2, J, tx_done.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
// Line states are encoded as {d_plus, d_minus}.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } tx_state_e;

    // SYNC pattern; sent LSB first, so the wire sees 0000_0001.
    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    // Consecutive ones after which a zero is forced onto the wire.
    localparam int         STUFF_LIMIT  = 6;
    // Bit times of SE0 at the start of end-of-packet.
    localparam int         EOP_SE0_BITS = 2;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // NRZI: a 0 toggles between J and K, a 1 holds the current level.
    function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
        if (bit_val) begin
            return line;
        end
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-time generator for the USB transmit encoder.
// Counts 0..CLKS_PER_BIT-1; o_bit_edge is high on the last clk of each bit
// time, i.e. the clk whose rising edge starts the next bit.
// i_clear holds the count at zero.
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    output logic o_bit_edge
);

    localparam int         CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap     = (r_cnt == LAST);
    assign o_bit_edge = w_wrap;

    // Free-running bit counter, wrapping at the end of each bit time.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, LSB-first byte serialisation,
// bit stuffing, NRZI onto d_plus/d_minus, then EOP (SE0 x2, J).
// Optional build macro USB_TX_ABORT_EN adds the tx_abort input, which ends
// a packet with eight unstuffed ones (a deliberate stuff error) before EOP.
//
// Byte handshake: tx_data is taken on a rising edge when tx_data_valid and
// tx_data_ready are both high in the preceding clk. tx_data_ready is only
// ever high in IDLE or on the final clk of a byte's last real data bit, so
// it reads as a one-clk pulse per accepted byte; tx_data_valid is ignored
// at all other times.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
`ifdef USB_TX_ABORT_EN
    input  logic       tx_abort,
`endif
    output logic       tx_data_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done
);

    tx_state_e  r_state;
    logic [1:0] r_line;       // current {d_plus, d_minus}
    logic [7:0] r_byte;       // byte being serialised
    logic [2:0] r_bit_idx;    // index of the data/SYNC bit on the wire
    logic [2:0] r_ones_cnt;   // consecutive ones sent so far
    logic       r_is_stuff;   // wire currently carries a stuffed zero
    logic       r_more;       // next byte already loaded behind a stuff bit
    logic       r_eop_cnt;    // SE0 bit-time counter
    logic       r_busy;
    logic       r_done;
    logic       r_abort_req;  // abort seen, waiting for the next bit edge
    logic       r_aborting;   // sending the eight unstuffed ones

    logic w_edge;
    logic w_abort_in;
    logic w_in_pkt;
    logic w_abort_now;
    logic w_stuff_due;
    logic w_byte_end;
    logic w_accept;

`ifdef USB_TX_ABORT_EN
    assign w_abort_in = tx_abort;
`else
    assign w_abort_in = 1'b0;
`endif

    usb_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (r_state == IDLE),
        .o_bit_edge (w_edge)
    );

    assign w_in_pkt    = (r_state == SYNC) || (r_state == DATA);
    assign w_abort_now = (w_abort_in || r_abort_req) && w_in_pkt && !r_aborting;
    assign w_stuff_due = (r_ones_cnt == 3'(STUFF_LIMIT));
    // Last clk of a byte's bit 7 (a real data bit, never the stuff bit).
    assign w_byte_end  = (r_state == DATA) && w_edge && !r_is_stuff &&
                         (r_bit_idx == 3'd7) && !r_aborting && !w_abort_now;
    assign w_accept    = tx_data_valid && ((r_state == IDLE) || w_byte_end);

    assign tx_data_ready = w_accept;
    assign d_plus        = r_line[1];
    assign d_minus       = r_line[0];
    assign tx_busy       = r_busy;
    assign tx_done       = r_done;

    // Packet FSM: picks the next wire symbol at every bit edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_line      <= LINE_J;
            r_byte      <= '0;
            r_bit_idx   <= '0;
            r_ones_cnt  <= '0;
            r_is_stuff  <= 1'b0;
            r_more      <= 1'b0;
            r_eop_cnt   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_abort_req <= 1'b0;
            r_aborting  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort_now && !w_edge) begin
                r_abort_req <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (tx_data_valid) begin
                        // First SYNC bit goes out on the accept edge.
                        r_byte      <= tx_data;
                        r_line      <= nrzi_next(LINE_J, SYNC_BYTE[0]);
                        r_ones_cnt  <= '0;
                        r_bit_idx   <= '0;
                        r_is_stuff  <= 1'b0;
                        r_more      <= 1'b0;
                        r_abort_req <= 1'b0;
                        r_aborting  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= SYNC;
                    end
                end
                SYNC, DATA: begin
                    if (w_edge) begin
                        if (w_abort_now) begin
                            // First of eight held ones; stuffing is off from here.
                            r_aborting  <= 1'b1;
                            r_abort_req <= 1'b0;
                            r_bit_idx   <= '0;
                            r_is_stuff  <= 1'b0;
                            r_state     <= DATA;
                        end else if (r_aborting) begin
                            if (r_bit_idx == 3'd7) begin
                                r_line     <= LINE_SE0;
                                r_eop_cnt  <= 1'b0;
                                r_ones_cnt <= '0;
                                r_aborting <= 1'b0;
                                r_state    <= EOP_SE0;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end else if (r_state == SYNC) begin
                            if (r_bit_idx == 3'd7) begin
                                r_line     <= nrzi_next(r_line, r_byte[0]);
                                r_ones_cnt <= r_byte[0] ? r_ones_cnt + 3'd1 : 3'd0;
                                r_bit_idx  <= '0;
                                r_state    <= DATA;
                            end else begin
                                r_line     <= nrzi_next(r_line, SYNC_BYTE[r_bit_idx + 3'd1]);
                                r_ones_cnt <= SYNC_BYTE[r_bit_idx + 3'd1] ? r_ones_cnt + 3'd1 : 3'd0;
                                r_bit_idx  <= r_bit_idx + 3'd1;
                            end
                        end else if (w_stuff_due) begin
                            // Stuffed zero; the data position does not advance.
                            r_line     <= nrzi_next(r_line, 1'b0);
                            r_ones_cnt <= '0;
                            r_is_stuff <= 1'b1;
                            if (w_accept) begin
                                r_byte <= tx_data;
                                r_more <= 1'b1;
                            end
                        end else if (r_bit_idx != 3'd7) begin
                            r_line     <= nrzi_next(r_line, r_byte[r_bit_idx + 3'd1]);
                            r_ones_cnt <= r_byte[r_bit_idx + 3'd1] ? r_ones_cnt + 3'd1 : 3'd0;
                            r_bit_idx  <= r_bit_idx + 3'd1;
                            r_is_stuff <= 1'b0;
                        end else if (w_accept) begin
                            r_byte     <= tx_data;
                            r_line     <= nrzi_next(r_line, tx_data[0]);
                            r_ones_cnt <= tx_data[0] ? r_ones_cnt + 3'd1 : 3'd0;
                            r_bit_idx  <= '0;
                            r_is_stuff <= 1'b0;
                        end else if (r_more) begin
                            r_line     <= nrzi_next(r_line, r_byte[0]);
                            r_ones_cnt <= r_byte[0] ? r_ones_cnt + 3'd1 : 3'd0;
                            r_bit_idx  <= '0;
                            r_is_stuff <= 1'b0;
                            r_more     <= 1'b0;
                        end else begin
                            r_line      <= LINE_SE0;
                            r_eop_cnt   <= 1'b0;
                            r_ones_cnt  <= '0;
                            r_is_stuff  <= 1'b0;
                            r_abort_req <= 1'b0;
                            r_state     <= EOP_SE0;
                        end
                    end
                end
                EOP_SE0: begin
                    if (w_edge) begin
                        if (r_eop_cnt == 1'(EOP_SE0_BITS - 1)) begin
                            r_line  <= LINE_J;
                            r_state <= EOP_J;
                        end else begin
                            r_eop_cnt <= r_eop_cnt + 1'b1;
                        end
                    end
                end
                EOP_J: begin
                    if (w_edge) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_line  <= LINE_J;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder (CLKS_PER_BIT = 8). A bit-level model turns each
// packet into the expected wire symbol per bit time plus the bit times at
// which the next byte must be accepted; the run loop compares every clk.
module tb_usb_tx_encoder;

  localparam int CPB = 8;
  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_busy;
  logic       tx_done;
`ifdef USB_TX_ABORT_EN
  logic       tx_abort;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
`ifdef USB_TX_ABORT_EN
    .tx_abort      (tx_abort),
`endif
    .tx_data_ready (tx_data_ready),
    .d_plus        (d_plus),
    .d_minus       (d_minus),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];   // expected wire symbol per bit time
  int         rdy_q[$];   // bit times whose last clk must show ready
  logic [7:0] pkt_q[$];   // bytes of the packet under test

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] m_line;
  int         m_ones;
  int         m_b;
  int         m_abort_bit;
  bit         m_ab;

  task automatic emit(input logic v);
    if (!v) m_line = (m_line == J) ? K : J;
    exp_q.push_back(m_line);
    m_ones = v ? m_ones + 1 : 0;
    if (m_b == m_abort_bit) m_ab = 1'b1;
    m_b++;
  endtask

  task automatic build_expected(input int abort_bit);
    logic [7:0] sync_b;
    logic [7:0] cur;
    exp_q.delete();
    rdy_q.delete();
    m_line = J;
    m_ones = 0;
    m_b = 0;
    m_ab = 1'b0;
    m_abort_bit = abort_bit;
    sync_b = 8'h80;
    for (int i = 0; i < 8; i++) if (!m_ab) emit(sync_b[i]);
    for (int j = 0; j < pkt_q.size(); j++) begin
      cur = pkt_q[j];
      for (int i = 0; i < 8; i++) begin
        if (!m_ab) begin
          emit(cur[i]);
          if (i == 7 && j < pkt_q.size() - 1 && !m_ab) rdy_q.push_back(m_b - 1);
          if (!m_ab && m_ones == 6) emit(1'b0);
        end
      end
    end
    if (m_ab) for (int i = 0; i < 8; i++) exp_q.push_back(m_line);
    exp_q.push_back(SE0);
    exp_q.push_back(SE0);
    exp_q.push_back(J);
  endtask

  // ---------------- driver ----------------
  task automatic run_packet(input string name, input int abort_bit);
    int nbits;
    int idx;
    logic [1:0] cur;
    logic exp_rdy;
    build_expected(abort_bit);
    nbits = exp_q.size();
    @(negedge clk);
    tx_data = pkt_q[0];
    tx_data_valid = 1'b1;
    #1;
    check({name, "_rdy_start"}, tx_data_ready, 1'b1);
    idx = 1;
    cur = J;
    for (int i = 0; i < nbits * CPB; i++) begin
      @(negedge clk);
      if (i % CPB == 0) cur = exp_q.pop_front();
      check($sformatf("%s_line_b%0d", name, i / CPB), {tx_busy, tx_done, d_plus, d_minus},
            {1'b1, 1'b0, cur});
      if (idx < pkt_q.size()) begin
        tx_data = pkt_q[idx];
        tx_data_valid = 1'b1;
      end else begin
        tx_data = 8'($urandom_range(0, 255));
        tx_data_valid = 1'b0;
      end
`ifdef USB_TX_ABORT_EN
      tx_abort = (abort_bit >= 0) && (i == abort_bit * CPB + 3);
`endif
      #1;
      exp_rdy = (i % CPB == CPB - 1) && (rdy_q.size() > 0) && (rdy_q[0] == i / CPB);
      check($sformatf("%s_rdy_b%0d", name, i / CPB), tx_data_ready, exp_rdy);
      if (exp_rdy) void'(rdy_q.pop_front());
      if (tx_data_ready) idx++;
    end
    @(negedge clk);
    check({name, "_done"}, {tx_busy, tx_done, d_plus, d_minus}, {2'b01, J});
    tx_data_valid = 1'b0;
    @(negedge clk);
    check({name, "_idle"}, {tx_busy, tx_done, d_plus, d_minus}, {2'b00, J});
    check({name, "_rdy_left"}, rdy_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_seen;
    n_rst = 1'b0;
    tx_data = 8'h00;
    tx_data_valid = 1'b0;
`ifdef USB_TX_ABORT_EN
    tx_abort = 1'b0;
`endif
    #12;
    check("reset_state", {tx_busy, tx_done, tx_data_ready, d_plus, d_minus}, {3'b000, J});
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {tx_busy, tx_done, d_plus, d_minus}, {2'b00, J});

    pkt_q = '{8'h00};               run_packet("byte00", -1);
    pkt_q = '{8'hFF};               run_packet("byteFF", -1);
    pkt_q = '{8'hFF, 8'hFF};        run_packet("FF_FF", -1);
    pkt_q = '{8'hA5, 8'h3C};        run_packet("A5_3C", -1);
    pkt_q = '{8'hFC};               run_packet("FC_end_stuff", -1);
    pkt_q = '{8'hFC, 8'h7F};        run_packet("FC_7F_cross", -1);
    pkt_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    run_packet("rand3", -1);
`ifdef USB_TX_ABORT_EN
    pkt_q = '{8'h5A, 8'h12};        run_packet("abort", 11);
`endif

    // Reset in the middle of DATA: line must snap to J without a clock.
    @(negedge clk);
    tx_data = 8'hC3;
    tx_data_valid = 1'b1;
    @(negedge clk);
    tx_data_valid = 1'b0;
    repeat (70) @(negedge clk);
    check("pre_reset_busy", tx_busy, 1'b1);
    #2;
    n_rst = 1'b0;
    #1;
    check("rst_async", {tx_busy, tx_done, tx_data_ready, d_plus, d_minus}, {3'b000, J});
    @(negedge clk);
    n_rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done || tx_busy || {d_plus, d_minus} != J) done_seen++;
    end
    check("rst_no_done", done_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
